ps2_rx_mux: RTL
===============

Name: ps2_rx_mux

Overview:
- Parametrised multi-channel PS/2 receiver. NUM_CH independent PS/2 device ports, each in keyboard or mouse packet mode.
- Per-frame odd-parity, framing and inter-bit timeout checks.
- One packet buffered per channel; lossless round-robin arbitration into a shared 64-bit host FIFO with back-pressure.
- Sits between board PS/2 pins and the host-bound input FIFO.

Parameters:
- NUM_CH, 2, number of PS/2 channels (1..8)
- FILT_LEN, 8, PS/2 clock glitch-filter length in cycles (even, >=4)
- TIMEOUT_CYC, 50000, cycles without a PS/2 clock edge before a partial frame or packet is discarded
- TO_W, 16, timeout counter width; must hold TIMEOUT_CYC

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous and active-high
- ps2_clk_in  in  NUM_CH  raw PS/2 clock per channel, asynchronous
- ps2_d_in  in  NUM_CH  raw PS/2 data per channel, asynchronous
- ch_mode_in  in  NUM_CH  per channel: 0 = keyboard, 1 = mouse; sampled only while that channel is idle
- act_out  out  NUM_CH  high while the channel is receiving data bits
- drop_out  out  NUM_CH  sticky, set when a packet is lost because the channel buffer is full; cleared only by rst
- wr_en_out  out  1  one-cycle FIFO write strobe
- wr_d_out  out  64  FIFO write data
- wr_full_in  in  1  FIFO full

Behaviour:
- Reset (synchronous): all outputs 0, all receivers IDLE, buffers empty, arbiter pointer at channel 0.
- Input conditioning:
  - Each ps2_clk_in/ps2_d_in passes through a 2-FF synchroniser.
  - The synchronised clock shifts into a FILT_LEN history register.
  - A rising edge is detected only when history = upper half all 1, lower half all 0 (FILT_LEN=8: 8'hF0).
- Frame receiver states:
  - IDLE: edge with d=0 -> DATA; d=1 -> stay.
  - DATA: shift 8 bits LSB-first -> PARITY.
  - PARITY: capture bit -> STOP.
  - STOP: requires d=1.
  - A frame is good if the stop bit is 1 and data ^ parity has odd weight; a good frame delivers a byte to the packet assembler.
  - A bad stop bit or bad parity discards the byte and the partial packet, and returns to IDLE.
- Timeout:
  - The counter resets on every filtered edge.
  - If it reaches TIMEOUT_CYC while not IDLE, or while a partial packet is held, the frame and partial packet are discarded and the channel returns to IDLE.
- Keyboard packet assembly:
  - Bytes with bit7=1 are prefixes, shifted in.
  - A byte with bit7=0 completes the packet.
  - A 4th prefix discards the packet.
- Mouse packet assembly:
  - Exactly 3 bytes form a packet.
  - Byte 0 must have bit3=1; otherwise that byte is dropped to resync.
- Packet word format:
  - [63:60] channel index.
  - [59:57] byte count (1..4).
  - [56] mode.
  - [31:0] bytes right-aligned, last byte in [7:0], unused bytes 0.
  - Keyboard E0 F0 74 -> 32'h00E0F074.
  - Mouse 08,10,F0 -> 32'h000810F0.
  - All other bits 0.
- Buffering:
  - A completed packet enters the channel's pending register in the cycle after the completing stop edge.
  - If the pending register is still full, the new packet is dropped and drop_out[ch] is set.
- Arbitration:
  - Each cycle with wr_full_in=0 and at least one pending channel, grant the first pending channel at or after the pointer.
  - Registered output: wr_en_out=1 and wr_d_out=word on the next cycle; the granted pending register clears; the pointer moves to grant+1 mod NUM_CH.
  - Otherwise wr_en_out=0 and wr_d_out=0.
  - wr_full_in=1 blocks all grants; no data is lost while pending registers hold.
  - Packet-complete to wr_en_out latency when uncontended: 2 cycles.
- Simultaneous events:
  - A buffer clears by grant and refills by a new packet in the same cycle: the new packet is accepted, no drop.
- Mode change mid-packet: ignored until IDLE with no partial packet.

Optional Feature:
- Macro PS2_RX_ERR_WORD_EN.
- Defined:
  - A parity, stop or timeout discard queues an error word through the same pending buffer and arbiter.
  - Error word: [63:60] channel index, [59:57]=0, [55] set, [49:48] code (1 parity, 2 stop, 3 timeout), remaining bits 0.
  - A full buffer drops the error word and sets drop_out.
- Undefined: errors are discarded silently and bit 55 is always 0.

Decomposition:
- Package ps2_pkg holds:
  - frame-state enum (IDLE, DATA, PARITY, STOP);
  - packet-word field positions;
  - error codes;
  - mode encodings;
  - keyboard prefix limit (3) and mouse packet length (3).
- Sub-module ps2_rx_frame: synchroniser, filter, frame FSM, parity and timeout; outputs byte_valid, byte, err, err_code, act.
  - Instantiated NUM_CH times by generate.
- Packet assembly, buffers and arbiter stay in ps2_rx_mux.

Test Plan:
- Ch0 keyboard sends E0,F0,74 -> one wr_en_out, wr_d_out=64'h0600_0000_00E0_F074.
- Ch1 mouse sends 08,10,F0 -> wr_d_out=64'h1700_0000_0008_10F0.
- Ch0 frame 1C with wrong parity, then 1C correct -> exactly one word, payload 32'h0000001C; with macro, error word code 1 first.
- Ch0 stops after 4 data bits, then after TIMEOUT_CYC sends 1C -> only the 1C word appears.
- wr_full_in=1 while ch0 and ch1 each complete a packet, release -> ch0 word, then ch1 word next cycle, drop_out=0.
- wr_full_in held, ch0 completes 2 packets -> first word later delivered, drop_out[0]=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the multi-channel PS/2 receiver.
// Packet-word layout helpers keep field positions in one place.
package ps2_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} frame_state_e;
    typedef enum logic [1:0] {ERR_NONE, ERR_PARITY, ERR_STOP, ERR_TIMEOUT} err_code_e;
    typedef enum logic {MODE_KBD, MODE_MOUSE} ch_mode_e;

    localparam logic [2:0] KBD_PREFIX_MAX = 3'd3;
    localparam logic [2:0] MOUSE_PKT_LEN  = 3'd3;
    localparam int MOUSE_SYNC_BIT = 3;

    localparam int W_CH_LSB   = 60;
    localparam int W_CNT_LSB  = 57;
    localparam int W_MODE_BIT = 56;
    localparam int W_ERR_BIT  = 55;
    localparam int W_CODE_LSB = 48;

    function automatic logic [63:0] pkt_word(input logic [3:0] ch, input logic [2:0] cnt,
                                             input logic mode, input logic [31:0] data);
        logic [63:0] w;
        w = '0;
        w[W_CH_LSB +: 4]  = ch;
        w[W_CNT_LSB +: 3] = cnt;
        w[W_MODE_BIT]     = mode;
        w[31:0]           = data;
        return w;
    endfunction

    function automatic logic [63:0] err_word(input logic [3:0] ch, input logic [1:0] code);
        logic [63:0] w;
        w = '0;
        w[W_CH_LSB +: 4]   = ch;
        w[W_ERR_BIT]       = 1'b1;
        w[W_CODE_LSB +: 2] = code;
        return w;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// One PS/2 frame receiver: 2-FF sync, clock glitch filter, 11-bit frame FSM, parity and timeout.
// Latency: byte_valid/err pulse one cycle after the filtered stop-bit edge (or timeout expiry).
// Backpressure: none; downstream must accept every pulse.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int TO_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_d,
    input  logic       pkt_busy,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       err,
    output err_code_e  err_code,
    output logic       act,
    output logic       idle
);

    localparam logic [FILT_LEN-1:0] EDGE_PAT = {{(FILT_LEN/2){1'b1}}, {(FILT_LEN/2){1'b0}}};
    localparam logic [TO_W-1:0]     TO_LIM   = TO_W'(TIMEOUT_CYC);

    logic [1:0]          clk_sync, d_sync;
    logic [FILT_LEN-1:0] hist;
    frame_state_e        state, state_n;
    logic [7:0]          sr, sr_n;
    logic [2:0]          bit_cnt, cnt_n;
    logic                par, par_n;
    logic [TO_W-1:0]     to_cnt, to_n;
    logic                byte_valid_n, err_n, timeout, clk_edge, d;
    err_code_e           code_n;

    // Newest sample enters at the MSB, so the pattern marks a clean low-to-high transition.
    assign clk_edge = (hist == EDGE_PAT);
    assign d        = d_sync[1];
    assign timeout  = !clk_edge && (to_cnt == TO_LIM) && (state != ST_IDLE || pkt_busy);
    assign act      = (state == ST_DATA);
    assign idle     = (state == ST_IDLE);
    assign rx_byte  = sr;

    always_comb begin
        state_n      = state;
        sr_n         = sr;
        cnt_n        = bit_cnt;
        par_n        = par;
        byte_valid_n = 1'b0;
        err_n        = 1'b0;
        code_n       = err_code;
        to_n         = clk_edge ? '0 : ((to_cnt == TO_LIM) ? to_cnt : to_cnt + 1'b1);
        if (timeout) begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
            code_n  = ERR_TIMEOUT;
        end else if (clk_edge) begin
            case (state)
                ST_IDLE: begin
                    if (!d) begin
                        state_n = ST_DATA;
                        cnt_n   = 3'd0;
                    end
                end
                ST_DATA: begin
                    sr_n  = {d, sr[7:1]};
                    cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = ST_PARITY;
                end
                ST_PARITY: begin
                    par_n   = d;
                    state_n = ST_STOP;
                end
                default: begin
                    state_n = ST_IDLE;
                    if (!d) begin
                        err_n  = 1'b1;
                        code_n = ERR_STOP;
                    end else if (!(^{sr, par})) begin
                        err_n  = 1'b1;
                        code_n = ERR_PARITY;
                    end else begin
                        byte_valid_n = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync   <= 2'b11;
            d_sync     <= 2'b11;
            hist       <= '1;
            state      <= ST_IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            par        <= 1'b0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            d_sync     <= {d_sync[0], ps2_d};
            hist       <= {clk_sync[1], hist[FILT_LEN-1:1]};
            state      <= state_n;
            sr         <= sr_n;
            bit_cnt    <= cnt_n;
            par        <= par_n;
            to_cnt     <= to_n;
            byte_valid <= byte_valid_n;
            err        <= err_n;
            err_code   <= code_n;
        end
    end

endmodule

// File: rtl/ps2_rx_mux.sv
// Multi-channel PS/2 receiver: per-channel packet assembly, one pending word each, round-robin into a 64-bit FIFO.
// Latency: 2 cycles from packet completion to wr_en_out when uncontended; PS2_RX_ERR_WORD_EN also queues error words.
// Backpressure: wr_full_in stalls all grants; a packet arriving at a still-full pending slot is dropped and flagged.
module ps2_rx_mux
    import ps2_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int TO_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ps2_clk_in,
    input  logic [NUM_CH-1:0] ps2_d_in,
    input  logic [NUM_CH-1:0] ch_mode_in,
    output logic [NUM_CH-1:0] act_out,
    output logic [NUM_CH-1:0] drop_out,
    output logic              wr_en_out,
    output logic [63:0]       wr_d_out,
    input  logic              wr_full_in
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] pend_vld;
    logic [63:0]       pend_word [NUM_CH];
    logic [CW-1:0]     ptr, gnt_idx, scan_idx;
    logic              gnt_vld;
    int                j;

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        j        = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            scan_idx = CW'(j);
            if (!gnt_vld && pend_vld[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        if (wr_full_in) gnt_vld = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            wr_en_out <= 1'b0;
            wr_d_out  <= '0;
        end else if (gnt_vld) begin
            ptr       <= (gnt_idx == CW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
            wr_en_out <= 1'b1;
            wr_d_out  <= pend_word[gnt_idx];
        end else begin
            wr_en_out <= 1'b0;
            wr_d_out  <= '0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic       byte_vld, err, idle, gnt_hit, pkt_done, err_load, new_vld;
        logic [7:0] rx_byte;
        err_code_e  err_code;
        ch_mode_e   mode;
        logic [23:0] pk_buf, buf_n;
        logic [2:0]  pk_cnt, cnt_n;
        logic [63:0] new_word, pw;
        logic        pv, dr;

        ps2_rx_frame #(
            .FILT_LEN   (FILT_LEN),
            .TIMEOUT_CYC(TIMEOUT_CYC),
            .TO_W       (TO_W)
        ) u_frame (
            .clk       (clk),
            .rst       (rst),
            .ps2_clk   (ps2_clk_in[i]),
            .ps2_d     (ps2_d_in[i]),
            .pkt_busy  (pk_cnt != 3'd0),
            .byte_valid(byte_vld),
            .rx_byte   (rx_byte),
            .err       (err),
            .err_code  (err_code),
            .act       (act_out[i]),
            .idle      (idle)
        );

        assign gnt_hit = gnt_vld && (gnt_idx == CW'(i));
`ifdef PS2_RX_ERR_WORD_EN
        assign err_load = err;
`else
        assign err_load = 1'b0;
`endif

        always_comb begin
            buf_n    = pk_buf;
            cnt_n    = pk_cnt;
            pkt_done = 1'b0;
            if (err) begin
                buf_n = '0;
                cnt_n = '0;
            end else if (byte_vld) begin
                if (mode == MODE_KBD) begin
                    if (!rx_byte[7]) begin
                        pkt_done = 1'b1;
                        buf_n    = '0;
                        cnt_n    = '0;
                    end else if (pk_cnt == KBD_PREFIX_MAX) begin
                        buf_n = '0;
                        cnt_n = '0;
                    end else begin
                        buf_n = {pk_buf[15:0], rx_byte};
                        cnt_n = pk_cnt + 3'd1;
                    end
                end else if (pk_cnt == 3'd0 && !rx_byte[MOUSE_SYNC_BIT]) begin
                    // Out-of-sync first byte: drop it and wait for a byte with the sync bit.
                    buf_n = '0;
                end else if (pk_cnt == MOUSE_PKT_LEN - 3'd1) begin
                    pkt_done = 1'b1;
                    buf_n    = '0;
                    cnt_n    = '0;
                end else begin
                    buf_n = {pk_buf[15:0], rx_byte};
                    cnt_n = pk_cnt + 3'd1;
                end
            end
        end

        assign new_vld  = pkt_done || err_load;
        assign new_word = pkt_done ? pkt_word(4'(i), pk_cnt + 3'd1, mode, {pk_buf, rx_byte})
                                   : err_word(4'(i), err_code);

        always_ff @(posedge clk) begin
            if (rst) begin
                pk_buf <= '0;
                pk_cnt <= '0;
                mode   <= MODE_KBD;
                pv     <= 1'b0;
                pw     <= '0;
                dr     <= 1'b0;
            end else begin
                pk_buf <= buf_n;
                pk_cnt <= cnt_n;
                if (idle && pk_cnt == 3'd0) mode <= ch_mode_e'(ch_mode_in[i]);
                if (gnt_hit) pv <= 1'b0;
                if (new_vld) begin
                    if (pv && !gnt_hit) begin
                        dr <= 1'b1;
                    end else begin
                        pv <= 1'b1;
                        pw <= new_word;
                    end
                end
            end
        end

        assign pend_vld[i]  = pv;
        assign pend_word[i] = pw;
        assign drop_out[i]  = dr;
    end

endmodule
